vmx_isa_dispatcher: RTL

//  Parametrised instruction dispatcher between the ISA command FIFO and the DMA/VMX datapath.

---
 rtl/vmx_isa_dispatcher.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vmx_isa_dispatcher.sv
// ISA command dispatcher: pops one instruction, rebases its address, issues a DMA
// command or runs a fixed-length multiply, and retires one instruction at a time.
module vmx_isa_dispatcher #(
   parameter int unsigned ADDR_W     = 22,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned LOAD_LEN   = 4,
   parameter int unsigned STORE_LEN  = 8,
   parameter int unsigned MUL_CYCLES = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [31:0]               ISA_FIFO_DATA,
   input  logic                      ISA_FIFO_EMPTY,
   output logic                      ISA_FIFO_RDEN,
   input  logic [ADDR_W-1:0]         BASE_ADDRESS,
   input  logic                      BASE_WE,
   output logic                      DMA_CMD_VALID,
   input  logic                      DMA_CMD_READY,
   output logic [2+ADDR_W+LEN_W-1:0] DMA_CMD,
   input  logic                      DMA_DONE,
   output logic                      MUL_START,
   output logic                      BUSY,
   output logic                      ERR_ILLEGAL,
   output logic                      ADDR_OVF,
   output logic                      INSTR_DONE,
   output logic [CNT_W-1:0]          INSTR_COUNT
);

   localparam int unsigned MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_MUL, S_ERR} state_t;

   state_t                      state_q;
   logic [MC_W-1:0]             mul_cnt_q;
   logic [ADDR_W-1:0]           base_q;
   logic                        valid_q;
   logic [2+ADDR_W+LEN_W-1:0]   cmd_q;
   logic                        mul_start_q;
   logic                        err_q;
   logic                        ovf_q;
   logic [CNT_W-1:0]            count_q;

   logic [1:0]                  op;
   logic [ADDR_W-1:0]           addr_fld;
   logic [LEN_W-1:0]            len_fld;
   logic [ADDR_W:0]             sum;
   logic [LEN_W-1:0]            len_eff;
   logic                        pop;
   logic                        retire;

   assign op       = ISA_FIFO_DATA[31:30];
   assign addr_fld = ISA_FIFO_DATA[ADDR_W-1:0];
   assign len_fld  = ISA_FIFO_DATA[ADDR_W+LEN_W-1:ADDR_W];
   assign sum      = {1'b0, addr_fld} + {1'b0, base_q};
   assign len_eff  = (len_fld != '0) ? len_fld :
                     ((op == 2'b11) ? LEN_W'(LOAD_LEN) : LEN_W'(STORE_LEN));

   // Gated by RST_N so the pop strobe is also forced low while reset is held.
   assign pop    = RST_N && (state_q == S_IDLE) && !ISA_FIFO_EMPTY;
   assign retire = ((state_q == S_WAIT) && DMA_DONE) ||
                   ((state_q == S_MUL) && (mul_cnt_q == '0));

   assign ISA_FIFO_RDEN = pop;
   assign INSTR_DONE    = retire;
   assign BUSY          = (state_q != S_IDLE);
   assign DMA_CMD_VALID = valid_q;
   assign DMA_CMD       = cmd_q;
   assign MUL_START     = mul_start_q;
   assign ERR_ILLEGAL   = err_q;
   assign ADDR_OVF      = ovf_q;
   assign INSTR_COUNT   = count_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         mul_cnt_q   <= '0;
         base_q      <= '0;
         valid_q     <= 1'b0;
         cmd_q       <= '0;
         mul_start_q <= 1'b0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         count_q     <= '0;
      end else begin
         mul_start_q <= 1'b0;
         err_q       <= 1'b0;
         if (BASE_WE) base_q <= BASE_ADDRESS;
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  case (op)
                     2'b11, 2'b10: begin
                        state_q <= S_ISSUE;
                        valid_q <= 1'b1;
                        cmd_q   <= {op, sum[ADDR_W-1:0], len_eff};
                        if (sum[ADDR_W]) ovf_q <= 1'b1;
                     end
                     2'b01: begin
                        state_q     <= S_MUL;
                        mul_start_q <= 1'b1;
                        mul_cnt_q   <= MC_W'(MUL_CYCLES - 1);
                     end
                     default: begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  endcase
               end
            end
            S_ISSUE: begin
               if (DMA_CMD_READY) begin
                  valid_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (DMA_DONE) state_q <= S_IDLE;
            end
            S_MUL: begin
               if (mul_cnt_q == '0) state_q <= S_IDLE;
               else mul_cnt_q <= mul_cnt_q - 1'b1;
            end
            S_ERR: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (retire) count_q <= count_q + 1'b1;
      end
   end

endmodule
